// File: rtl/send_data_fsm_if.sv
// Signal bundle between the dump sequencer and its surroundings: debug-unit
// control, memory read port and UART transmitter handshake.
`timescale 1ns/1ps
interface send_data_fsm_if #(
    parameter int UART_BITS  = 8,
    parameter int ADDRS_BITS = 7,
    parameter int DATA_BITS  = 4 * UART_BITS
);
    logic                  i_start;
    logic [UART_BITS-1:0]  i_count;
    logic [ADDRS_BITS-1:0] o_mem_addr;
    logic [DATA_BITS-1:0]  i_mem_data;
    logic                  o_tx_start;
    logic [UART_BITS-1:0]  o_tx_data;
    logic                  i_tx_done;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  i_start, i_count, i_mem_data, i_tx_done,
        output o_mem_addr, o_tx_start, o_tx_data, o_busy, o_done
    );

    modport slave (
        output i_start, i_count, i_mem_data, i_tx_done,
        input  o_mem_addr, o_tx_start, o_tx_data, o_busy, o_done
    );
endinterface

// File: rtl/send_data_fsm.sv
// Debug-unit transmit sequencer: sends a word count byte, then each memory
// word as four bytes MSB first, through the UART TX start/done handshake.
`timescale 1ns/1ps
module send_data_fsm #(
    parameter int UART_BITS  = 8,
    parameter int ADDRS_BITS = 7,
    parameter int DATA_BITS  = 4 * UART_BITS
) (
    input  logic               clk,
    input  logic               rst,
    send_data_fsm_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE, SEND_CNT, WAIT_CNT, READ, LOAD, SEND_BYTE, WAIT_BYTE, DONE
    } state_t;

    localparam logic [UART_BITS:0] WORD_ONE = 1;

    state_t                state_q,    state_d;
    logic [UART_BITS-1:0]  cnt_q,      cnt_d;
    logic [UART_BITS:0]    word_q,     word_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [DATA_BITS-1:0]  shift_q,    shift_d;
    logic [ADDRS_BITS-1:0] addr_q,     addr_d;
    logic [UART_BITS-1:0]  tx_data_q,  tx_data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // The address is loaded on entry to READ so that read data is already
    // valid when LOAD samples it one cycle later.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    cnt_d     = bus.i_count;
                    word_d    = '0;
                    addr_d    = '0;
                    tx_data_d = bus.i_count;
                    state_d   = SEND_CNT;
                end
            end
            SEND_CNT: state_d = WAIT_CNT;
            WAIT_CNT: begin
                if (bus.i_tx_done) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = word_q[ADDRS_BITS-1:0];
                        state_d = READ;
                    end
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                shift_d    = bus.i_mem_data;
                byte_idx_d = '0;
                tx_data_d  = bus.i_mem_data[DATA_BITS-1 -: UART_BITS];
                state_d    = SEND_BYTE;
            end
            SEND_BYTE: state_d = WAIT_BYTE;
            WAIT_BYTE: begin
                if (bus.i_tx_done) begin
                    shift_d    = shift_q << UART_BITS;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q != 2'd3) begin
                        tx_data_d = shift_q[DATA_BITS-UART_BITS-1 -: UART_BITS];
                        state_d   = SEND_BYTE;
                    end else begin
                        word_d = word_q + WORD_ONE;
                        if (word_d == {1'b0, cnt_q}) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = word_d[ADDRS_BITS-1:0];
                            state_d = READ;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_tx_start = (state_q == SEND_CNT) || (state_q == SEND_BYTE);
        bus.o_busy     = (state_q != IDLE);
        bus.o_done     = (state_q == DONE);
        bus.o_tx_data  = tx_data_q;
        bus.o_mem_addr = addr_q;
    end

endmodule
